// File: rtl/regfile_sb_if.sv
// Register file bus: writeback write port, issue reservation port and the
// operand-fetch read ports, grouped so the decode stage connects with one
// instance. clk/rst_n stay plain ports on the register file.
//
// Handshake semantics: wr_en and rsv_en are single-cycle strobes. They are
// sampled at the rising clock edge and have no ready/backpressure; the
// register file accepts every strobe once init_done is high. Strobes seen
// while init_done is low are dropped. Read ports are combinational with no
// handshake: rd_data/rd_busy follow rd_addr within the same cycle.
//
// dbg_state mirrors the sweep FSM (0 = clearing, 1 = running) for checkers.
interface regfile_sb_if #(
   parameter int N_REGS  = 32,
   parameter int R_WIDTH = 32,
   parameter int N_RD    = 2
);
   localparam int W_ADDR = $clog2(N_REGS);

   logic                     init_done;
   logic                     dbg_state;
   logic                     wr_en;
   logic [W_ADDR-1:0]        wr_addr;
   logic [R_WIDTH-1:0]       wr_data;
   logic                     rsv_en;
   logic [W_ADDR-1:0]        rsv_addr;
   logic [N_RD*W_ADDR-1:0]   rd_addr;
   logic [N_RD*R_WIDTH-1:0]  rd_data;
   logic [N_RD-1:0]          rd_busy;

   // Pipeline side: drives writes, reservations and read addresses.
   modport master (
      output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
      input  init_done, dbg_state, rd_data, rd_busy
   );

   // Register file side.
   modport slave (
      input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr,
      output init_done, dbg_state, rd_data, rd_busy
   );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard for the decode stage.
// - x0 reads as zero and never holds state or a pending bit.
// - After reset a sequencer clears x1..x(N_REGS-1), one register per cycle;
//   init_done rises when the sweep finishes.
// - Issue reserves a destination (pending bit set); writeback clears it.
// Optional feature, enabled by defining REGFILE_BYPASS_EN: same-cycle
// write-to-read forwarding on every read port.
module regfile_sb #(
   parameter int N_REGS  = 32,
   parameter int R_WIDTH = 32,
   parameter int N_RD    = 2
) (
   input logic          clk,
   input logic          rst_n,
   regfile_sb_if.slave  bus
);
   localparam int W_ADDR = $clog2(N_REGS);
   localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(N_REGS - 1);

   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   state_t              state;
   logic [W_ADDR-1:0]   cnt;
   logic                init_done_q;
   logic [N_REGS-1:0]   pend;
   logic [R_WIDTH-1:0]  regs [N_REGS];

   logic wr_hit;
   logic rsv_hit;

   // Accepted strobes: only in RUN and never to x0.
   assign wr_hit  = (state == S_RUN) && bus.wr_en  && (bus.wr_addr  != '0);
   assign rsv_hit = (state == S_RUN) && bus.rsv_en && (bus.rsv_addr != '0);

   assign bus.init_done = init_done_q;
   assign bus.dbg_state = (state == S_RUN);

   // Sweep FSM, clear counter, init_done and the pending scoreboard.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_INIT;
         cnt         <= W_ADDR'(1);
         init_done_q <= 1'b0;
         pend        <= '0;
      end else begin
         case (state)
            S_INIT: begin
               if (cnt == LAST_ADDR) begin
                  state       <= S_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: begin
               // Reservation is applied after the write so it wins on a
               // same-address collision.
               if (wr_hit)  pend[bus.wr_addr]  <= 1'b0;
               if (rsv_hit) pend[bus.rsv_addr] <= 1'b1;
            end
            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

   // Register storage: sweep clear during INIT, writeback during RUN.
   // Not reset directly; slot 0 is never written and never read out.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == S_INIT) begin
            regs[cnt] <= '0;
         end else if (wr_hit) begin
            regs[bus.wr_addr] <= bus.wr_data;
         end
      end
   end

   // Combinational read ports, each independent of the others.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int i = 0; i < N_RD; i++) begin
         logic [W_ADDR-1:0] a;
         a = bus.rd_addr[i*W_ADDR +: W_ADDR];
         if (state == S_RUN && a != '0) begin
            bus.rd_data[i*R_WIDTH +: R_WIDTH] = regs[a];
            bus.rd_busy[i]                    = pend[a];
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight writeback; a same-cycle reservation of
            // the same register keeps it busy.
            if (wr_hit && bus.wr_addr == a) begin
               bus.rd_data[i*R_WIDTH +: R_WIDTH] = bus.wr_data;
               bus.rd_busy[i] = bus.rsv_en && (bus.rsv_addr == a);
            end
`endif
         end
      end
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Next-generation integer register file for the decode stage.
- Adds a parametrised number of read ports, a sequenced hardware clear after reset, and a per-register pending-write scoreboard used for hazard detection.
- Single write port from writeback; reservation port from issue; read ports feed operand fetch.
- x0 is hardwired to zero and is never stored.

Parameters:
- N_REGS, 32, number of architectural registers; power of two, at least 4.
- R_WIDTH, 32, register data width in bits.
- N_RD, 2, number of read ports; range 1..4.
- W_ADDR (localparam), $clog2(N_REGS), register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- init_done  out  1  high once the post-reset clear sweep has completed.
- wr_en  in  1  writeback write strobe.
- wr_addr  in  W_ADDR  writeback destination address.
- wr_data  in  R_WIDTH  writeback data.
- rsv_en  in  1  issue reservation strobe; marks a destination register as pending.
- rsv_addr  in  W_ADDR  reserved destination address.
- rd_addr  in  N_RD*W_ADDR  read addresses; port i occupies bits [i*W_ADDR +: W_ADDR].
- rd_data  out  N_RD*R_WIDTH  read data; port i occupies bits [i*R_WIDTH +: R_WIDTH].
- rd_busy  out  N_RD  port i's register has an outstanding reservation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n sampled 0 at a clk edge):
  - state=INIT, clear counter cnt=1, init_done=0, all pending bits=0.
  - Held in this condition while rst_n stays low.
  - Register storage is not reset directly.
- INIT state (rst_n=1):
  - Each edge writes regs[cnt]<=0.
  - If cnt==N_REGS-1: state<=RUN and init_done<=1. Otherwise cnt<=cnt+1.
  - Result: init_done rises on the (N_REGS-1)th edge after rst_n deasserts (31 edges at default).
- During INIT:
  - wr_en and rsv_en are ignored.
  - rd_data is forced to 0 and rd_busy to 0.
- RUN state:
  - Write: wr_en && wr_addr!=0 -> regs[wr_addr]<=wr_data and pend[wr_addr]<=0 at the edge.
  - Reserve: rsv_en && rsv_addr!=0 -> pend[rsv_addr]<=1 at the edge.
  - Reserve and write to the same address in the same cycle: reserve wins, pend stays 1, data is still written.
  - Writes and reservations to x0 are dropped; pend[0] is always 0.
  - Write to an address with pend=0 is legal: data is written and pend stays 0.
- Read ports:
  - Purely combinational, zero latency, independent of each other.
  - rd_data[i] = regs[rd_addr[i]], or 0 when rd_addr[i]==0.
  - rd_busy[i] = pend[rd_addr[i]], subject to the bypass rule below.
- Reset mid-operation: rst_n=0 in RUN or in INIT restarts the sweep from cnt=1 and clears all pending bits immediately at that edge.
- No other outputs are registered. init_done is the only registered output.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, port i hits when wr_en && wr_addr!=0 && wr_addr==rd_addr[i]. On a hit:
  - rd_data[i]=wr_data in the same cycle (write-to-read forwarding).
  - rd_busy[i]=0, unless rsv_en && rsv_addr==rd_addr[i] in the same cycle, in which case rd_busy[i]=1.
- Undefined: no forwarding. A same-cycle read returns the old value, and rd_busy reflects the registered pend bit. The new data is visible from the next cycle.

Test Plan:
- Reset clear: preload reg5=0xDEAD_BEEF, pulse rst_n low 2 cycles -> init_done=0 for exactly 31 edges after deassert; then reading reg5 returns 0x0000_0000 and every rd_busy=0.
- Write/read: in RUN, write reg7=0x1234_5678, next cycle read port0=7, port1=0 -> rd_data0=0x1234_5678, rd_data1=0.
- Scoreboard: rsv_en on reg3 -> next cycle rd_busy for reg3 =1; write reg3=0xA5 -> next cycle rd_busy=0 and data=0xA5; same-cycle rsv and write on reg3 -> pend stays 1.
- Bypass: same cycle wr reg9=0xCAFE and read reg9 (old 0x11) -> with REGFILE_BYPASS_EN: 0xCAFE and busy=0; without: 0x11 that cycle, 0xCAFE the next.
- x0: wr_en to x0 with 0xFFFF_FFFF plus rsv_en to x0 -> read x0=0 and rd_busy=0.
- Mid-sweep reset: assert rst_n at INIT cnt=10 -> sweep restarts and init_done rises 31 edges after the new deassert; writes during INIT have no effect.
